cpu_mem_ctrl: RTL and testbench

Owns port A of the Chip-8 CPU dual-port memory and shares it between the CPU and a program loader (a byte stream from the host link).
- RUN mode: the CPU has the port.
- LOAD mode: the CPU is halted, and the loader writes a program to consecutive addresses starting at the program base.
- After the load it releases the CPU with a restart pulse.

Port B (video) is untouched.

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/cpu_mem_load_ptr.sv | 53 +++++
 rtl/cpu_mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cpu_mem_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the Chip-8 CPU memory port A controller.
package cpu_mem_pkg;

   localparam int unsigned CHIP8_ADDR_W = 12;
   localparam int unsigned CHIP8_DATA_W = 8;

   localparam logic [CHIP8_ADDR_W-1:0] CHIP8_PROG_BASE = 12'h200;
   localparam logic [CHIP8_ADDR_W-1:0] CHIP8_MEM_TOP   = 12'hFFF;

   // Port A ownership states; CLEAR is reachable only with CPU_MEM_CTRL_CLEAR_EN
   typedef logic [1:0] state_t;
   localparam state_t ST_RUN   = 2'd0;
   localparam state_t ST_LOAD  = 2'd1;
   localparam state_t ST_CLEAR = 2'd2;

endpackage

// File: rtl/cpu_mem_load_ptr.sv
// Loader address pointer, saturating byte counter and sticky overflow flag.
module cpu_mem_load_ptr
   import cpu_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W    = CHIP8_ADDR_W,
   parameter logic [ADDR_W-1:0] LOAD_BASE = CHIP8_PROG_BASE,
   parameter logic [ADDR_W-1:0] LOAD_MAX  = CHIP8_MEM_TOP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              rewind,
   input  logic              ptr_inc,
   input  logic              cnt_inc,
   input  logic              set_ovf,
   output logic [ADDR_W-1:0] ptr,
   output logic [ADDR_W-1:0] count,
   output logic              overflow,
   output logic              full_c
);

   localparam logic [ADDR_W-1:0] WINDOW = LOAD_MAX - LOAD_BASE + ADDR_W'(1);

   // Window is filled once LOAD_MAX has been written; the pointer never wraps past it
   assign full_c = (count == WINDOW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= LOAD_BASE;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (clr || rewind) begin
            ptr <= LOAD_BASE;
         end else if (ptr_inc && (ptr != LOAD_MAX)) begin
            ptr <= ptr + ADDR_W'(1);
         end

         if (clr) begin
            count <= '0;
         end else if (cnt_inc && !full_c) begin
            count <= count + ADDR_W'(1);
         end

         if (clr) begin
            overflow <= 1'b0;
         end else if (set_ovf) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Port A arbiter between the Chip-8 CPU and the host program loader.
// Define CPU_MEM_CTRL_CLEAR_EN to zero LOAD_BASE..LOAD_MAX before each load.
module cpu_mem_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W    = CHIP8_ADDR_W,
   parameter int unsigned       DATA_W    = CHIP8_DATA_W,
   parameter logic [ADDR_W-1:0] LOAD_BASE = CHIP8_PROG_BASE,
   parameter logic [ADDR_W-1:0] LOAD_MAX  = CHIP8_MEM_TOP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_halt,
   output logic              cpu_restart,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              ld_busy,
   output logic [ADDR_W-1:0] ld_count,
   output logic              ld_overflow,
   output logic              mem_en,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef CPU_MEM_CTRL_CLEAR_EN
   localparam state_t START_ST = ST_CLEAR;
`else
   localparam state_t START_ST = ST_LOAD;
`endif

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic              full_c;
   logic              clr;
   logic              rewind;
   logic              ptr_inc;
   logic              cnt_inc;
   logic              set_ovf;

   cpu_mem_load_ptr #(
      .ADDR_W    (ADDR_W),
      .LOAD_BASE (LOAD_BASE),
      .LOAD_MAX  (LOAD_MAX)
   ) u_load_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .rewind   (rewind),
      .ptr_inc  (ptr_inc),
      .cnt_inc  (cnt_inc),
      .set_ovf  (set_ovf),
      .ptr      (ptr),
      .count    (ld_count),
      .overflow (ld_overflow),
      .full_c   (full_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, port A mux and pointer controls
   always_comb begin
      state_nxt = state;
      cpu_gnt   = 1'b0;
      ld_ready  = 1'b0;
      mem_en    = 1'b0;
      mem_write = 1'b0;
      mem_addr  = ptr;
      mem_wdata = '0;
      clr       = 1'b0;
      rewind    = 1'b0;
      ptr_inc   = 1'b0;
      cnt_inc   = 1'b0;
      set_ovf   = 1'b0;

      case (state)
         ST_RUN: begin
            cpu_gnt   = cpu_req;
            mem_en    = cpu_req;
            mem_write = cpu_req & cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (ld_start) begin
               state_nxt = START_ST;
               clr       = 1'b1;
            end
         end

         ST_LOAD: begin
            ld_ready = !ld_start;
            if (ld_start) begin
               state_nxt = START_ST;
               clr       = 1'b1;
            end else if (ld_valid) begin
               // Bytes past a filled window are dropped and flagged
               if (full_c) begin
                  set_ovf = 1'b1;
               end else begin
                  mem_en    = 1'b1;
                  mem_write = 1'b1;
                  mem_wdata = ld_data;
                  ptr_inc   = 1'b1;
                  cnt_inc   = 1'b1;
               end
               if (ld_last) begin
                  state_nxt = ST_RUN;
               end
            end
         end

`ifdef CPU_MEM_CTRL_CLEAR_EN
         ST_CLEAR: begin
            mem_en    = 1'b1;
            mem_write = 1'b1;
            if (ld_start) begin
               clr = 1'b1;
            end else if (ptr == LOAD_MAX) begin
               rewind    = 1'b1;
               state_nxt = ST_LOAD;
            end else begin
               ptr_inc = 1'b1;
            end
         end
`endif

         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   // Read return and restart pulse; a read granted on the ld_start cycle still returns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpu_rvalid  <= 1'b0;
         cpu_restart <= 1'b0;
      end else begin
         cpu_rvalid  <= cpu_gnt & ~cpu_we;
         cpu_restart <= (state == ST_LOAD) && (state_nxt == ST_RUN);
      end
   end

   assign cpu_rdata = mem_rdata;
   assign cpu_halt  = (state != ST_RUN);
   assign ld_busy   = (state != ST_RUN);

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Self-checking bench for cpu_mem_ctrl: behavioural port-A model plus directed loads.
module tb_cpu_mem_ctrl;

   localparam int WIN = 'hE00;
`ifdef CPU_MEM_CTRL_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [11:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_gnt, cpu_rvalid, cpu_halt, cpu_restart;
   logic [7:0]  cpu_rdata;
   logic        ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
   logic [7:0]  ld_data = '0;
   logic        ld_ready, ld_busy, ld_overflow;
   logic [11:0] ld_count;
   logic        mem_en, mem_write;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   int total = 0;
   int bad = 0;
   int n_restart = 0;

   cpu_mem_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .cpu_halt(cpu_halt), .cpu_restart(cpu_restart),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_count(ld_count), .ld_overflow(ld_overflow),
      .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory behind port A, preloaded with a per-address pattern
   bit         ram_wr [4096];
   logic [7:0] ram_d  [4096];
   bit         exp_wr [4096];
   logic [7:0] exp_d  [4096];

   function automatic logic [7:0] init_pat(input int a);
      return 8'(a) ^ 8'hA5;
   endfunction

   function automatic logic [7:0] ram_rd(input int a);
      return ram_wr[a] ? ram_d[a] : init_pat(a);
   endfunction

   function automatic logic [7:0] exp_rd(input int a);
      return exp_wr[a] ? exp_d[a] : init_pat(a);
   endfunction

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_write) begin
            ram_wr[mem_addr] <= 1'b1;
            ram_d[mem_addr]  <= mem_wdata;
         end else begin
            mem_rdata <= ram_rd(int'(mem_addr));
         end
      end
   end

   // Behavioural model: who owns the port, how many bytes landed, what memory must hold
   bit          m_busy, m_clr, m_ovf, m_restart, m_rvalid;
   int          m_cnt, m_idx;
   logic [11:0] m_raddr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_clr <= 1'b0; m_ovf <= 1'b0; m_restart <= 1'b0; m_rvalid <= 1'b0;
         m_cnt <= 0; m_idx <= 0;
      end else begin
         m_restart <= 1'b0;
         m_rvalid  <= 1'b0;
         if (!m_busy) begin
            if (cpu_req && cpu_we) begin
               exp_wr[cpu_addr] <= 1'b1;
               exp_d[cpu_addr]  <= cpu_wdata;
            end
            m_rvalid <= cpu_req && !cpu_we;
            m_raddr  <= cpu_addr;
            if (ld_start) begin
               m_busy <= 1'b1; m_cnt <= 0; m_ovf <= 1'b0; m_clr <= CLR_EN; m_idx <= 0;
            end
         end else if (m_clr) begin
            exp_wr['h200 + m_idx] <= 1'b1;
            exp_d['h200 + m_idx]  <= 8'h00;
            if (ld_start) m_idx <= 0;
            else if (m_idx == WIN - 1) m_clr <= 1'b0;
            else m_idx <= m_idx + 1;
         end else if (ld_start) begin
            m_cnt <= 0; m_ovf <= 1'b0; m_clr <= CLR_EN; m_idx <= 0;
         end else if (ld_valid) begin
            if (m_cnt < WIN) begin
               exp_wr['h200 + m_cnt] <= 1'b1;
               exp_d['h200 + m_cnt]  <= ld_data;
               m_cnt <= m_cnt + 1;
            end else begin
               m_ovf <= 1'b1;
            end
            if (ld_last) begin
               m_busy    <= 1'b0;
               m_restart <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   initial begin : cmp
      logic        e_gnt, e_en, e_we, e_rdy;
      logic [11:0] e_addr;
      logic [7:0]  e_wd;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (!m_busy) begin
               e_gnt = cpu_req; e_en = cpu_req; e_we = cpu_req & cpu_we;
               e_addr = cpu_addr; e_wd = cpu_wdata; e_rdy = 1'b0;
            end else if (m_clr) begin
               e_gnt = 1'b0; e_en = 1'b1; e_we = 1'b1;
               e_addr = 12'('h200 + m_idx); e_wd = 8'h00; e_rdy = 1'b0;
            end else begin
               e_gnt = 1'b0; e_rdy = !ld_start;
               e_we = ld_valid && !ld_start && (m_cnt < WIN);
               e_en = e_we;
               e_addr = 12'('h200 + m_cnt);
               e_wd = e_we ? ld_data : 8'h00;
            end
            chk("cpu_gnt", 32'(cpu_gnt), 32'(e_gnt));
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_write", 32'(mem_write), 32'(e_we));
            chk("ld_ready", 32'(ld_ready), 32'(e_rdy));
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we || m_busy) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("cpu_halt", 32'(cpu_halt), 32'(m_busy));
            chk("ld_busy", 32'(ld_busy), 32'(m_busy));
            chk("cpu_restart", 32'(cpu_restart), 32'(m_restart));
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rvalid));
            if (m_rvalid) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rd(int'(m_raddr))));
            chk("ld_count", 32'(ld_count), 32'(m_cnt));
            chk("ld_overflow", 32'(ld_overflow), 32'(m_ovf));
            if (cpu_restart) n_restart++;
         end
      end
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      bit ok;
      ok = 1'b0;
      ld_valid = 1'b1; ld_data = d; ld_last = last;
      for (int n = 0; n < 8000 && !ok; n++) begin
         @(negedge clk);
         ok = ld_ready;
         @(posedge clk);
         #1;
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("ld_ready_wait", 32'(ok), 32'd1);
   endtask

   task automatic pulse_start();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   initial begin : main
      int r0;
      int nclr;

      // Reset values
      #12;
      chk("rst_halt", 32'(cpu_halt), 0);
      chk("rst_restart", 32'(cpu_restart), 0);
      chk("rst_rvalid", 32'(cpu_rvalid), 0);
      chk("rst_ovf", 32'(ld_overflow), 0);
      chk("rst_count", 32'(ld_count), 0);
      chk("rst_busy", 32'(ld_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // CPU read of 0x050, write/read-back of 0x123
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h050;
      @(negedge clk);
      chk("t1_gnt", 32'(cpu_gnt), 1);
      chk("t1_en", 32'(mem_en), 1);
      chk("t1_write", 32'(mem_write), 0);
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t1_rvalid", 32'(cpu_rvalid), 1);
      chk("t1_rdata", 32'(cpu_rdata), 32'hF5);
      tick();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h3C;
      tick();
      cpu_we = 1'b0;
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      chk("t1_readback", 32'(cpu_rdata), 32'h3C);
      tick();

      // Three-byte load
      r0 = n_restart;
      pulse_start();
      send(8'hA2, 1'b0);
      send(8'h1E, 1'b0);
      send(8'h60, 1'b1);
      @(negedge clk);
      chk("t2_restart", 32'(cpu_restart), 1);
      chk("t2_halt", 32'(cpu_halt), 0);
      chk("t2_count", 32'(ld_count), 3);
      chk("t2_m200", 32'(ram_rd('h200)), 32'hA2);
      chk("t2_m201", 32'(ram_rd('h201)), 32'h1E);
      chk("t2_m202", 32'(ram_rd('h202)), 32'h60);
      tick();
      cpu_req = 1'b1; cpu_addr = 12'h202;
      @(negedge clk);
      chk("t2_gnt_after", 32'(cpu_gnt), 1);
      tick();
      cpu_req = 1'b0;
      tick();
      chk("t2_restart_once", 32'(n_restart - r0), 1);

      // ld_start together with a CPU read; held request during load
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h201; ld_start = 1'b1;
      @(negedge clk);
      chk("t3_gnt", 32'(cpu_gnt), 1);
      tick();
      ld_start = 1'b0;
      @(negedge clk);
      chk("t3_rvalid", 32'(cpu_rvalid), 1);
      chk("t3_rdata", 32'(cpu_rdata), 32'h1E);
      chk("t3_gnt_load", 32'(cpu_gnt), 0);
      repeat (3) tick();
      cpu_req = 1'b0;
      send(8'h11, 1'b1);
      tick();

      // Overflow: 0xE01 bytes
      pulse_start();
      for (int i = 0; i <= WIN; i++) send(8'(i), (i == WIN));
      @(negedge clk);
      chk("t4_ovf", 32'(ld_overflow), 1);
      chk("t4_count", 32'(ld_count), 32'hE00);
      chk("t4_mFFF", 32'(ram_rd('hFFF)), 32'hFF);
      chk("t4_mFFE", 32'(ram_rd('hFFE)), 32'hFE);
      chk("t4_m000", 32'(ram_rd('h000)), 32'hA5);
      tick();

      // Reset mid-load, then ld_start mid-load
      pulse_start();
      for (int i = 0; i < 5; i++) send(8'(8'h51 + 8'(i)), 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_halt", 32'(cpu_halt), 0);
      chk("t5_busy", 32'(ld_busy), 0);
      chk("t5_count", 32'(ld_count), 0);
      chk("t5_restart", 32'(cpu_restart), 0);
      chk("t5_rvalid", 32'(cpu_rvalid), 0);
      chk("t5_m204", 32'(ram_rd('h204)), 32'h55);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      pulse_start();
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h77;
      @(negedge clk);
      chk("t5_rdy_start", 32'(ld_ready), 0);
      chk("t5_nowrite", 32'(mem_write), 0);
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      send(8'h88, 1'b1);
      @(negedge clk);
      chk("t5_m200", 32'(ram_rd('h200)), 32'h88);
      chk("t5_count1", 32'(ld_count), 1);
      tick();

`ifdef CPU_MEM_CTRL_CLEAR_EN
      // Clear sweep before load
      pulse_start();
      nclr = 0;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (!mem_write) break;
         nclr++;
      end
      chk("t6_clear_cycles", 32'(nclr), 32'hE00);
      chk("t6_m300", 32'(ram_rd('h300)), 0);
      chk("t6_mFFF", 32'(ram_rd('hFFF)), 0);
      tick();
      send(8'h99, 1'b1);
      @(negedge clk);
      chk("t6_m200", 32'(ram_rd('h200)), 32'h99);
      chk("t6_m201", 32'(ram_rd('h201)), 0);
      tick();
`else
      nclr = 0;
      r0 = nclr;
`endif

      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
